// File: rtl/vld_st_sequencer.sv
// vld_st_sequencer: head-of-queue controller for the vector load/store buffer.
// Issues block-aligned miss requests for unfetched heads, forwards fill
// notifications to the buffer, replays fetched heads into the cache array,
// returns load data with the ROB ticket and pops the entry.
// Optional feature macro: VLD_SEQ_TIMEOUT_EN (WAIT_FILL watchdog that reissues
// the miss after TIMEOUT_CYCLES cycles without a fill).
module vld_st_sequencer #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BLOCK_ID_START = 5,
  parameter int unsigned MICROOP_WIDTH  = 7,
  parameter int unsigned TICKET_WIDTH   = 5,
  parameter int unsigned SIZE_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // buffer head
  input  logic                     head_valid_i,
  input  logic                     head_is_store_i,
  input  logic                     head_is_fetched_i,
  input  logic [ADDR_BITS-1:0]     head_address_i,
  input  logic [DATA_WIDTH-1:0]    head_data_i,
  input  logic [MICROOP_WIDTH-1:0] head_microop_i,
  input  logic [TICKET_WIDTH-1:0]  head_ticket_i,
  input  logic [SIZE_WIDTH-1:0]    head_size_i,
  output logic                     pop_o,
  // fetched-status update to buffer
  output logic                     valid_update_o,
  output logic [ADDR_BITS-1:0]     update_address_o,
  // miss request
  output logic                     miss_req_valid_o,
  output logic [ADDR_BITS-1:0]     miss_req_addr_o,
  input  logic                     miss_req_ready_i,
  // fill notification
  input  logic                     fill_valid_i,
  input  logic [ADDR_BITS-1:0]     fill_address_i,
  // cache array access
  output logic                     cache_req_valid_o,
  output logic                     cache_req_we_o,
  output logic [ADDR_BITS-1:0]     cache_req_addr_o,
  output logic [DATA_WIDTH-1:0]    cache_req_data_o,
  output logic [SIZE_WIDTH-1:0]    cache_req_size_o,
  output logic [MICROOP_WIDTH-1:0] cache_req_microop_o,
  input  logic                     cache_req_ready_i,
  input  logic                     cache_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]    cache_resp_data_i,
  // load writeback
  output logic                     wb_valid_o,
  output logic [TICKET_WIDTH-1:0]  wb_ticket_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  output logic                     busy_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MISS_REQ  = 3'd1,
    S_WAIT_FILL = 3'd2,
    S_ACCESS    = 3'd3,
    S_WAIT_RESP = 3'd4
  } state_t;

  // Clears the offset-within-block bits so the miss targets the whole block.
  localparam logic [ADDR_BITS-1:0] BLOCK_MASK =
    ~((ADDR_BITS'(1) << BLOCK_ID_START) - ADDR_BITS'(1));

  state_t state_q, state_d;

`ifdef VLD_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog counter register: cycles spent in WAIT_FILL without a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic (and watchdog counter update when enabled).
  always_comb begin
    state_d = state_q;
`ifdef VLD_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (head_valid_i) begin
          state_d = head_is_fetched_i ? S_ACCESS : S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        // Fetched status is deliberately not re-sampled here: once the miss
        // is presented it must complete its handshake.
        if (miss_req_ready_i) begin
          state_d = S_WAIT_FILL;
`ifdef VLD_SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT_FILL: begin
        if (head_is_fetched_i) begin
          state_d = S_ACCESS;
        end
`ifdef VLD_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_MISS_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_ACCESS: begin
        if (cache_req_ready_i) begin
          state_d = head_is_store_i ? S_IDLE : S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (cache_resp_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state; pop/writeback also qualify on
  // the accepting ready/response input of the same cycle.
  always_comb begin
    valid_update_o      = fill_valid_i;
    update_address_o    = fill_address_i;

    miss_req_valid_o    = (state_q == S_MISS_REQ);
    miss_req_addr_o     = head_address_i & BLOCK_MASK;

    cache_req_valid_o   = (state_q == S_ACCESS);
    cache_req_we_o      = head_is_store_i;
    cache_req_addr_o    = head_address_i;
    cache_req_data_o    = head_data_i;
    cache_req_size_o    = head_size_i;
    cache_req_microop_o = head_microop_i;

    wb_valid_o          = (state_q == S_WAIT_RESP) && cache_resp_valid_i;
    wb_ticket_o         = head_ticket_i;
    wb_data_o           = cache_resp_data_i;

    pop_o               = ((state_q == S_ACCESS) && cache_req_ready_i && head_is_store_i)
                        || ((state_q == S_WAIT_RESP) && cache_resp_valid_i);

    busy_o              = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_vld_st_sequencer.sv
// Self-checking bench for vld_st_sequencer. Expected miss addresses, cache
// requests and writebacks are queued when stimulus is driven and popped when
// the DUT presents them. Compile with VLD_SEQ_TIMEOUT_EN to check the watchdog.
module tb_vld_st_sequencer;

  localparam int AB = 32;
  localparam int DW = 32;
  localparam int MW = 7;
  localparam int TW = 5;
  localparam int SW = 3;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          head_valid_i, head_is_store_i, head_is_fetched_i;
  logic [AB-1:0] head_address_i;
  logic [DW-1:0] head_data_i;
  logic [MW-1:0] head_microop_i;
  logic [TW-1:0] head_ticket_i;
  logic [SW-1:0] head_size_i;
  logic          pop_o;
  logic          valid_update_o;
  logic [AB-1:0] update_address_o;
  logic          miss_req_valid_o;
  logic [AB-1:0] miss_req_addr_o;
  logic          miss_req_ready_i;
  logic          fill_valid_i;
  logic [AB-1:0] fill_address_i;
  logic          cache_req_valid_o, cache_req_we_o;
  logic [AB-1:0] cache_req_addr_o;
  logic [DW-1:0] cache_req_data_o;
  logic [SW-1:0] cache_req_size_o;
  logic [MW-1:0] cache_req_microop_o;
  logic          cache_req_ready_i;
  logic          cache_resp_valid_i;
  logic [DW-1:0] cache_resp_data_i;
  logic          wb_valid_o;
  logic [TW-1:0] wb_ticket_o;
  logic [DW-1:0] wb_data_o;
  logic          busy_o;

  vld_st_sequencer #(
    .ADDR_BITS(AB), .DATA_WIDTH(DW), .BLOCK_ID_START(5), .MICROOP_WIDTH(MW),
    .TICKET_WIDTH(TW), .SIZE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .head_valid_i(head_valid_i), .head_is_store_i(head_is_store_i),
    .head_is_fetched_i(head_is_fetched_i), .head_address_i(head_address_i),
    .head_data_i(head_data_i), .head_microop_i(head_microop_i),
    .head_ticket_i(head_ticket_i), .head_size_i(head_size_i),
    .pop_o(pop_o), .valid_update_o(valid_update_o), .update_address_o(update_address_o),
    .miss_req_valid_o(miss_req_valid_o), .miss_req_addr_o(miss_req_addr_o),
    .miss_req_ready_i(miss_req_ready_i),
    .fill_valid_i(fill_valid_i), .fill_address_i(fill_address_i),
    .cache_req_valid_o(cache_req_valid_o), .cache_req_we_o(cache_req_we_o),
    .cache_req_addr_o(cache_req_addr_o), .cache_req_data_o(cache_req_data_o),
    .cache_req_size_o(cache_req_size_o), .cache_req_microop_o(cache_req_microop_o),
    .cache_req_ready_i(cache_req_ready_i),
    .cache_resp_valid_i(cache_resp_valid_i), .cache_resp_data_i(cache_resp_data_i),
    .wb_valid_o(wb_valid_o), .wb_ticket_o(wb_ticket_o), .wb_data_o(wb_data_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic          we;
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] size;
    logic [MW-1:0] microop;
  } cache_exp_t;

  typedef struct packed {
    logic [TW-1:0] ticket;
    logic [DW-1:0] data;
  } wb_exp_t;

  logic [AB-1:0] exp_miss_q[$];
  cache_exp_t    exp_cache_q[$];
  wb_exp_t       exp_wb_q[$];

  // Inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic valid, input logic store, input logic fetched,
                          input logic [AB-1:0] addr, input logic [DW-1:0] data,
                          input logic [TW-1:0] ticket, input logic [SW-1:0] size,
                          input logic [MW-1:0] microop);
    head_valid_i      = valid;
    head_is_store_i   = store;
    head_is_fetched_i = fetched;
    head_address_i    = addr;
    head_data_i       = data;
    head_ticket_i     = ticket;
    head_size_i       = size;
    head_microop_i    = microop;
  endtask

  // Waits (sampling on falling edges) for a valid: 0 = miss request, 1 = cache request.
  task automatic wait_valid(input int which, input int max_cyc, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      cycles = i + 1;
      if ((which == 0 && miss_req_valid_o === 1'b1) || (which == 1 && cache_req_valid_o === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_head(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    miss_req_ready_i = 1'b1; cache_req_ready_i = 1'b1;
    fill_valid_i = 1'b0; fill_address_i = '0;
    cache_resp_valid_i = 1'b0; cache_resp_data_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy_o, pop_o, miss_req_valid_o, cache_req_valid_o, wb_valid_o, valid_update_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy/pop/miss/cache/wb/upd=%b required 000000",
               {busy_o, pop_o, miss_req_valid_o, cache_req_valid_o, wb_valid_o, valid_update_o});
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b required 0", busy_o); end
    $display("reset: released, busy=%b", busy_o);
  endtask

  task automatic test_fetched_store();
    int cyc; bit ok; cache_exp_t e;
    next_cycle();
    set_head(1'b1, 1'b1, 1'b1, 32'h1004, 32'hDEADBEEF, 5'd1, 3'd2, 7'h21);
    exp_cache_q.push_back('{we: 1'b1, addr: 32'h1004, data: 32'hDEADBEEF, size: 3'd2, microop: 7'h21});
    wait_valid(1, 10, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2) begin n_err++; $display("FAIL store_latency: ok=%0d cycles=%0d required ok=1 cycles=2", ok, cyc); end
    e = exp_cache_q.pop_front();
    n_cmp++;
    if ({cache_req_we_o, cache_req_addr_o, cache_req_data_o, cache_req_size_o, cache_req_microop_o} !== e) begin
      n_err++;
      $display("FAIL store_req: got we=%b addr=%h data=%h size=%0d uop=%h required we=%b addr=%h data=%h size=%0d uop=%h",
               cache_req_we_o, cache_req_addr_o, cache_req_data_o, cache_req_size_o, cache_req_microop_o,
               e.we, e.addr, e.data, e.size, e.microop);
    end
    n_cmp++;
    if (pop_o !== 1'b1) begin n_err++; $display("FAIL store_pop: pop=%b required 1", pop_o); end
    next_cycle();
    head_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || pop_o !== 1'b0) begin n_err++; $display("FAIL store_idle: busy=%b pop=%b required 0 0", busy_o, pop_o); end
    $display("fetched_store: addr=%h we=%b pop seen, latency=%0d", e.addr, e.we, cyc - 1);
  endtask

  task automatic test_miss_load();
    int cyc; bit ok; cache_exp_t e; wb_exp_t w; logic [AB-1:0] ma;
    next_cycle();
    set_head(1'b1, 1'b0, 1'b0, 32'h2044, 32'h0, 5'd5, 3'd2, 7'h11);
    exp_miss_q.push_back(32'h2040);
    wait_valid(0, 10, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2) begin n_err++; $display("FAIL miss_latency: ok=%0d cycles=%0d required ok=1 cycles=2", ok, cyc); end
    ma = exp_miss_q.pop_front();
    n_cmp++;
    if (miss_req_addr_o !== ma) begin n_err++; $display("FAIL miss_addr: got %h required %h", miss_req_addr_o, ma); end
    next_cycle();
    fill_valid_i = 1'b1; fill_address_i = 32'h2040;
    @(negedge clk);
    n_cmp++;
    if (valid_update_o !== 1'b1 || update_address_o !== 32'h2040 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL fill_forward: upd=%b addr=%h busy=%b required 1 00002040 1", valid_update_o, update_address_o, busy_o);
    end
    next_cycle();
    fill_valid_i = 1'b0;
    head_is_fetched_i = 1'b1;
    exp_cache_q.push_back('{we: 1'b0, addr: 32'h2044, data: 32'h0, size: 3'd2, microop: 7'h11});
    wait_valid(1, 10, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2) begin n_err++; $display("FAIL load_issue: ok=%0d cycles=%0d required ok=1 cycles=2", ok, cyc); end
    e = exp_cache_q.pop_front();
    n_cmp++;
    if ({cache_req_we_o, cache_req_addr_o, cache_req_size_o, cache_req_microop_o, pop_o} !== {e.we, e.addr, e.size, e.microop, 1'b0}) begin
      n_err++;
      $display("FAIL load_req: got we=%b addr=%h size=%0d uop=%h pop=%b required we=%b addr=%h size=%0d uop=%h pop=0",
               cache_req_we_o, cache_req_addr_o, cache_req_size_o, cache_req_microop_o, pop_o,
               e.we, e.addr, e.size, e.microop);
    end
    exp_wb_q.push_back('{ticket: 5'd5, data: 32'h12345678});
    next_cycle();
    cache_resp_valid_i = 1'b1; cache_resp_data_i = 32'h12345678;
    @(negedge clk);
    w = exp_wb_q.pop_front();
    n_cmp++;
    if ({wb_valid_o, pop_o, wb_ticket_o, wb_data_o} !== {1'b1, 1'b1, w.ticket, w.data}) begin
      n_err++;
      $display("FAIL load_wb: got wb=%b pop=%b ticket=%0d data=%h required 1 1 %0d %h",
               wb_valid_o, pop_o, wb_ticket_o, wb_data_o, w.ticket, w.data);
    end
    next_cycle();
    cache_resp_valid_i = 1'b0; head_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL load_idle: busy=%b required 0", busy_o); end
    $display("miss_load: miss=%h wb ticket=%0d data=%h", ma, w.ticket, w.data);
  endtask

  // Backpressured miss, then stray fill in WAIT_FILL, then reset in WAIT_RESP.
  task automatic test_backpressure_stray_reset();
    int cyc; bit ok; int hs; logic [AB-1:0] ma; cache_exp_t e;
    next_cycle();
    miss_req_ready_i = 1'b0;
    set_head(1'b1, 1'b0, 1'b0, 32'h3078, 32'h0, 5'd9, 3'd1, 7'h05);
    exp_miss_q.push_back(32'h3060);
    wait_valid(0, 10, cyc, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_miss_timeout: no miss request within 10 cycles"); end
    ma = exp_miss_q.pop_front();
    hs = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (miss_req_valid_o !== 1'b1 || miss_req_addr_o !== ma) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b addr=%h required 1 %h", k, miss_req_valid_o, miss_req_addr_o, ma);
      end
    end
    next_cycle();
    miss_req_ready_i = 1'b1;
    @(negedge clk);
    if (miss_req_valid_o === 1'b1) hs++;
    next_cycle();
    @(negedge clk);
    if (miss_req_valid_o === 1'b1) hs++;
    n_cmp++;
    if (hs != 1 || busy_o !== 1'b1) begin n_err++; $display("FAIL bp_handshake: handshakes=%0d busy=%b required 1 1", hs, busy_o); end
    $display("backpressure: miss=%h held 4 cycles, handshakes=%0d", ma, hs);

    next_cycle();
    fill_valid_i = 1'b1; fill_address_i = 32'h5000;
    @(negedge clk);
    n_cmp++;
    if ({valid_update_o, update_address_o, pop_o, wb_valid_o} !== {1'b1, 32'h5000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL stray_fill: upd=%b addr=%h pop=%b wb=%b required 1 00005000 0 0",
               valid_update_o, update_address_o, pop_o, wb_valid_o);
    end
    next_cycle();
    fill_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({miss_req_valid_o, cache_req_valid_o, busy_o} !== 3'b001) begin
      n_err++;
      $display("FAIL stray_fill_state: miss=%b cache=%b busy=%b required 0 0 1", miss_req_valid_o, cache_req_valid_o, busy_o);
    end
    $display("stray_fill: other block forwarded, still waiting");

    next_cycle();
    head_is_fetched_i = 1'b1;
    exp_cache_q.push_back('{we: 1'b0, addr: 32'h3078, data: 32'h0, size: 3'd1, microop: 7'h05});
    wait_valid(1, 10, cyc, ok);
    e = exp_cache_q.pop_front();
    n_cmp++;
    if (!ok || cache_req_addr_o !== e.addr || cache_req_we_o !== e.we) begin
      n_err++;
      $display("FAIL bp_load_req: ok=%0d addr=%h we=%b required 1 %h %b", ok, cache_req_addr_o, cache_req_we_o, e.addr, e.we);
    end
    next_cycle();
    rst_n = 1'b0;
    cache_resp_valid_i = 1'b1; cache_resp_data_i = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid_o, pop_o, busy_o, miss_req_valid_o, cache_req_valid_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid: wb/pop/busy/miss/cache=%b required 00000",
               {wb_valid_o, pop_o, busy_o, miss_req_valid_o, cache_req_valid_o});
    end
    next_cycle();
    rst_n = 1'b1; cache_resp_valid_i = 1'b0; head_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || exp_wb_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_idle: busy=%b pending_wb=%0d required 0 0", busy_o, exp_wb_q.size());
    end
    $display("reset_mid: WAIT_RESP aborted, busy=%b", busy_o);
  endtask

  task automatic test_stray_resp();
    next_cycle();
    head_valid_i = 1'b0;
    cache_resp_valid_i = 1'b1; cache_resp_data_i = 32'hA5A5A5A5;
    @(negedge clk);
    n_cmp++;
    if (wb_valid_o !== 1'b0 || pop_o !== 1'b0) begin n_err++; $display("FAIL stray_resp: wb=%b pop=%b required 0 0", wb_valid_o, pop_o); end
    next_cycle();
    cache_resp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL stray_resp_idle: busy=%b required 0", busy_o); end
    $display("stray_resp: ignored in IDLE");
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; cache_exp_t e;
    next_cycle();
    set_head(1'b1, 1'b1, 1'b1, 32'h1100, 32'h11111111, 5'd2, 3'd2, 7'h01);
    exp_cache_q.push_back('{we: 1'b1, addr: 32'h1100, data: 32'h11111111, size: 3'd2, microop: 7'h01});
    exp_cache_q.push_back('{we: 1'b1, addr: 32'h1200, data: 32'h22222222, size: 3'd2, microop: 7'h02});
    wait_valid(1, 10, cyc, ok);
    e = exp_cache_q.pop_front();
    n_cmp++;
    if (!ok || cache_req_addr_o !== e.addr || cache_req_data_o !== e.data || pop_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: ok=%0d addr=%h data=%h pop=%b required 1 %h %h 1", ok, cache_req_addr_o, cache_req_data_o, pop_o, e.addr, e.data);
    end
    next_cycle();
    set_head(1'b1, 1'b1, 1'b1, 32'h1200, 32'h22222222, 5'd3, 3'd2, 7'h02);
    @(negedge clk);
    n_cmp++;
    if (cache_req_valid_o !== 1'b0 || busy_o !== 1'b0 || pop_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_bubble: cache=%b busy=%b pop=%b required 0 0 0", cache_req_valid_o, busy_o, pop_o);
    end
    next_cycle();
    @(negedge clk);
    e = exp_cache_q.pop_front();
    n_cmp++;
    if (cache_req_valid_o !== 1'b1 || cache_req_addr_o !== e.addr || cache_req_data_o !== e.data || pop_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: cache=%b addr=%h data=%h pop=%b required 1 %h %h 1", cache_req_valid_o, cache_req_addr_o, cache_req_data_o, pop_o, e.addr, e.data);
    end
    next_cycle();
    head_valid_i = 1'b0;
    @(negedge clk);
    $display("back_to_back: two stores popped with one bubble");
  endtask

  task automatic test_timeout();
    int cyc; bit ok; logic [AB-1:0] ma;
    next_cycle();
    miss_req_ready_i = 1'b1;
    set_head(1'b1, 1'b0, 1'b0, 32'h4010, 32'h0, 5'd7, 3'd2, 7'h33);
    exp_miss_q.push_back(32'h4000);
    wait_valid(0, 10, cyc, ok);
    ma = exp_miss_q.pop_front();
    n_cmp++;
    if (!ok || miss_req_addr_o !== ma) begin n_err++; $display("FAIL to_first_miss: ok=%0d addr=%h required 1 %h", ok, miss_req_addr_o, ma); end
`ifdef VLD_SEQ_TIMEOUT_EN
    exp_miss_q.push_back(32'h4000);
    wait_valid(0, 4 * TO, cyc, ok);
    ma = exp_miss_q.pop_front();
    n_cmp++;
    if (!ok || cyc != TO + 1 || miss_req_addr_o !== ma) begin
      n_err++;
      $display("FAIL to_reissue: ok=%0d cycles=%0d addr=%h required 1 %0d %h", ok, cyc, miss_req_addr_o, TO + 1, ma);
    end
    $display("timeout: miss reissued after %0d cycles", cyc);
`else
    wait_valid(0, 4 * TO, cyc, ok);
    n_cmp++;
    if (ok) begin n_err++; $display("FAIL to_no_reissue: reissued after %0d cycles required none", cyc); end
    $display("timeout: disabled, no reissue in %0d cycles", 4 * TO);
`endif
    next_cycle();
    rst_n = 1'b0; head_valid_i = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || exp_miss_q.size() != 0 || exp_cache_q.size() != 0) begin
      n_err++;
      $display("FAIL final_state: busy=%b pending_miss=%0d pending_cache=%0d required 0 0 0",
               busy_o, exp_miss_q.size(), exp_cache_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetched_store();
    test_miss_load();
    test_backpressure_stray_reset();
    test_stray_resp();
    test_back_to_back();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
